// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the instruction decoder:
// machine-cycle phases, opcode groups and the fetch state.
package instr_fetch_sequencer_pkg;

    localparam int PC_W        = 12;
    localparam int STACK_DEPTH = 3;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OP_JCN     = 4'h1;
    localparam logic [3:0] OP_FIM_SRC = 4'h2;
    localparam logic [3:0] OP_FIN_JIN = 4'h3;
    localparam logic [3:0] OP_JUN     = 4'h4;
    localparam logic [3:0] OP_JMS     = 4'h5;
    localparam logic [3:0] OP_ISZ     = 4'h7;
    localparam logic [3:0] OP_BBL     = 4'hC;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } fetch_state_e;

    // FIM and FIN share their opcode with SRC and JIN; only an even opa is two-cycle.
    function automatic logic is_two_cycle(input logic [3:0] opr, input logic opa_lsb);
        case (opr)
            OP_JCN, OP_JUN, OP_JMS, OP_ISZ: return 1'b1;
            OP_FIM_SRC, OP_FIN_JIN:         return !opa_lsb;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Fetch-to-decoder/ROM signal bundle. The master modport is the fetch side.
interface instr_fetch_sequencer_if;
    import instr_fetch_sequencer_pkg::*;

    // No valid/ready: every signal is phase-timed against cycle, which the fetch
    // side owns; romData is sampled at M1/M2, ccIn/iszZero at X3.
    logic [3:0]      romData;
    logic            ccIn;
    logic            iszZero;
    logic [7:0]      pairData;
    logic [2:0]      cycle;
    logic            sync;
    logic [3:0]      busOut;
    logic            busOe;
    logic [3:0]      opr;
    logic [3:0]      opa;
    logic [7:0]      byte2;
    logic [7:0]      finData;
    logic            secondCycle;
    logic [PC_W-1:0] pc;

    modport master (
        input  romData, ccIn, iszZero, pairData,
        output cycle, sync, busOut, busOe, opr, opa, byte2, finData, secondCycle, pc
    );

    modport slave (
        output romData, ccIn, iszZero, pairData,
        input  cycle, sync, busOut, busOe, opr, opa, byte2, finData, secondCycle, pc
    );

endinterface

// File: rtl/instr_fetch_sequencer_stack.sv
// Three-entry circular return stack; overflow overwrites the oldest entry and
// underflow simply reads whatever the wrapped pointer addresses.
module return_stack3
    import instr_fetch_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rstN,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] pop_data_o
);
    logic [PC_W-1:0] entry_q [STACK_DEPTH];
    logic [1:0]      ptr_q, ptr_d, ptr_inc, ptr_dec;

    assign ptr_inc    = (ptr_q == 2'(STACK_DEPTH - 1)) ? 2'd0 : ptr_q + 2'd1;
    assign ptr_dec    = (ptr_q == 2'd0) ? 2'(STACK_DEPTH - 1) : ptr_q - 2'd1;
    // Pop retreats then reads, so the popped value sits one below the pointer.
    assign pop_data_o = entry_q[ptr_dec];

    always_comb begin
        ptr_d = ptr_q;
        if (push_i)     ptr_d = ptr_inc;
        else if (pop_i) ptr_d = ptr_dec;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr_q <= 2'd0;
            for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (push_i) entry_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch side of the 4004-style core: phase counter, program counter, ROM
// address/instruction capture on the multiplexed bus, and PC redirection.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstN,
    instr_fetch_sequencer_if.master bus
);
    logic [2:0]      cycle_q;
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      opr_q, opr_d, opa_q, opa_d;
    logic [7:0]      byte2_q, byte2_d, fin_data_q, fin_data_d;
    logic [PC_W-1:0] fetch_addr, pop_addr;
    logic            is_second, is_fin, at_x3, push, pop;

    assign is_second  = (state_q == SECOND);
    assign is_fin     = is_second && (opr_q == OP_FIN_JIN);
    assign at_x3      = (cycle_q == PH_X3);
    assign push       = at_x3 && is_second && (opr_q == OP_JMS);
    assign pop        = at_x3 && !is_second && (opr_q == OP_BBL);
    assign fetch_addr = is_fin ? {pc_q[PC_W-1:8], bus.pairData} : pc_q;

    always_comb begin
        state_d = state_q;
        if (at_x3) state_d = (!is_second && is_two_cycle(opr_q, opa_q[0])) ? SECOND : FIRST;
    end

    // opr/opa only load in the first cycle so the decoder sees them stable across both.
    always_comb begin
        opr_d      = opr_q;
        opa_d      = opa_q;
        byte2_d    = byte2_q;
        fin_data_d = fin_data_q;
        if (cycle_q == PH_M1) begin
            if (!is_second)  opr_d           = bus.romData;
            else if (is_fin) fin_data_d[7:4] = bus.romData;
            else             byte2_d[7:4]    = bus.romData;
        end else if (cycle_q == PH_M2) begin
            if (!is_second)  opa_d           = bus.romData;
            else if (is_fin) fin_data_d[3:0] = bus.romData;
            else             byte2_d[3:0]    = bus.romData;
        end
    end

    // Redirects at X3 use the already-incremented page, hence the JCN/ISZ page quirk.
    always_comb begin
        pc_d = pc_q;
        if (cycle_q == PH_M2 && !is_fin) pc_d = pc_q + PC_W'(1);
        if (at_x3) begin
            if (is_second) begin
                case (opr_q)
                    OP_JUN, OP_JMS: pc_d = {opa_q, byte2_q};
                    OP_JCN:         if (bus.ccIn)     pc_d = {pc_q[PC_W-1:8], byte2_q};
                    OP_ISZ:         if (!bus.iszZero) pc_d = {pc_q[PC_W-1:8], byte2_q};
                    default:        ;
                endcase
            end else begin
                case (opr_q)
                    OP_FIN_JIN: if (opa_q[0]) pc_d = {pc_q[PC_W-1:8], bus.pairData};
                    OP_BBL:     pc_d = pop_addr;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycle_q    <= PH_A1;
            state_q    <= FIRST;
            pc_q       <= '0;
            opr_q      <= '0;
            opa_q      <= '0;
            byte2_q    <= '0;
            fin_data_q <= '0;
        end else begin
            cycle_q    <= cycle_q + 3'd1;
            state_q    <= state_d;
            pc_q       <= pc_d;
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            byte2_q    <= byte2_d;
            fin_data_q <= fin_data_d;
        end
    end

    return_stack3 u_stack (
        .clk         (clk),
        .rstN        (rstN),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_q),
        .pop_data_o  (pop_addr)
    );

    always_comb begin
        case (cycle_q)
            PH_A1:   bus.busOut = fetch_addr[3:0];
            PH_A2:   bus.busOut = fetch_addr[7:4];
            PH_A3:   bus.busOut = fetch_addr[11:8];
            default: bus.busOut = 4'h0;
        endcase
    end

    assign bus.cycle       = cycle_q;
    assign bus.sync        = at_x3;
    assign bus.busOe       = (cycle_q <= PH_A3);
    assign bus.opr         = opr_q;
    assign bus.opa         = opa_q;
    assign bus.byte2       = byte2_q;
    assign bus.finData     = fin_data_q;
    assign bus.secondCycle = is_second;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: a bus-driven ROM model, directed scenarios
// and a randomized program checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_instr_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    instr_fetch_sequencer_if ifc ();

    instr_fetch_sequencer dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- ROM model on the multiplexed bus ----------------
    logic [7:0]  rom [4096];
    logic [11:0] rom_addr = 12'h000;

    always @(negedge clk) begin
        if (ifc.busOe) begin
            case (ifc.cycle)
                3'd0:    rom_addr[3:0]  <= ifc.busOut;
                3'd1:    rom_addr[7:4]  <= ifc.busOut;
                3'd2:    rom_addr[11:8] <= ifc.busOut;
                default: ;
            endcase
        end
    end

    assign ifc.romData = (ifc.cycle == 3'd3) ? rom[rom_addr][7:4] :
                         (ifc.cycle == 3'd4) ? rom[rom_addr][3:0] : 4'h0;

    // {cycle, pc, opr, opa, byte2, finData, secondCycle, sync, busOe, busOut}
    localparam logic [45:0] RESET_VEC = {3'd0, 12'h000, 4'h0, 4'h0, 8'h00, 8'h00,
                                         1'b0, 1'b0, 1'b1, 4'h0};

    function automatic logic [45:0] out_vec();
        return {ifc.cycle, ifc.pc, ifc.opr, ifc.opa, ifc.byte2, ifc.finData,
                ifc.secondCycle, ifc.sync, ifc.busOe, ifc.busOut};
    endfunction

    // ---------------- driver tasks ----------------
    logic [11:0] obs_addr1, obs_addr2;
    int          obs_sec;

    task automatic do_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Runs n machine cycles from an A1 negedge; ends on the next A1 negedge.
    task automatic exec_instr(input int n, input logic cc, input logic isz, input logic [7:0] pair);
        ifc.ccIn     = cc;
        ifc.iszZero  = isz;
        ifc.pairData = pair;
        obs_sec      = 0;
        for (int k = 0; k < 8 * n; k++) begin
            if ((k % 8) < 3) begin
                if (k < 8) obs_addr1[4 * (k % 8) +: 4] = ifc.busOut;
                else       obs_addr2[4 * (k % 8) +: 4] = ifc.busOut;
            end
            if (ifc.secondCycle) obs_sec++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", out_vec(), RESET_VEC);
        end
        rstN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [11:0] want_addr;
            want_addr = (k < 8) ? 12'h000 : 12'h001;
            checks++;
            if (ifc.sync !== ((k % 8) == 7)) begin
                errors++;
                $display("FAIL sync_k%0d: got %b expected %b", k, ifc.sync, (k % 8) == 7);
            end
            if ((k % 8) < 3) begin
                checks++;
                if (ifc.busOut !== want_addr[4 * (k % 8) +: 4]) begin
                    errors++;
                    $display("FAIL bus_nibble_k%0d: got %h expected %h", k, ifc.busOut,
                             want_addr[4 * (k % 8) +: 4]);
                end
            end
            if (k == 5) begin
                checks++;
                if (ifc.pc !== 12'h001) begin
                    errors++;
                    $display("FAIL pc_after_m2: got %h expected 001", ifc.pc);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_jun();
        rom[12'h000] = 8'h43; rom[12'h001] = 8'h21; rom[12'h321] = 8'h00;
        do_reset();
        exec_instr(2, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_sec !== 8) begin
            errors++; $display("FAIL jun_second_cycle: got %0d expected 8", obs_sec);
        end
        checks++;
        if (ifc.byte2 !== 8'h21) begin
            errors++; $display("FAIL jun_byte2: got %h expected 21", ifc.byte2);
        end
        checks++;
        if (ifc.pc !== 12'h321) begin
            errors++; $display("FAIL jun_pc: got %h expected 321", ifc.pc);
        end
        exec_instr(1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_addr1 !== 12'h321) begin
            errors++; $display("FAIL jun_next_fetch: got %h expected 321", obs_addr1);
        end
    endtask

    task automatic test_jcn();
        logic [11:0] where [3] = '{12'h010, 12'h010, 12'h0FE};
        logic        cc    [3] = '{1'b1, 1'b0, 1'b1};
        logic [11:0] want  [3] = '{12'h080, 12'h012, 12'h180};
        for (int i = 0; i < 3; i++) begin
            rom[12'h000] = 8'h40; rom[12'h001] = where[i][7:0];
            rom[where[i]] = 8'h14; rom[where[i] + 12'h001] = 8'h80;
            do_reset();
            exec_instr(2, 1'b0, 1'b0, 8'h00);
            exec_instr(2, cc[i], 1'b0, 8'h00);
            checks++;
            if (ifc.pc !== want[i]) begin
                errors++; $display("FAIL jcn_pc_%0d: got %h expected %h", i, ifc.pc, want[i]);
            end
        end
    endtask

    task automatic test_jms_bbl();
        logic [11:0] want [4] = '{12'h302, 12'h202, 12'h102, 12'h302};
        rom[12'h000] = 8'h51; rom[12'h001] = 8'h00;
        rom[12'h100] = 8'h52; rom[12'h101] = 8'h00; rom[12'h102] = 8'hC0;
        rom[12'h200] = 8'h53; rom[12'h201] = 8'h00; rom[12'h202] = 8'hC0;
        rom[12'h300] = 8'h54; rom[12'h301] = 8'h00; rom[12'h302] = 8'hC0;
        rom[12'h400] = 8'hC0;
        do_reset();
        repeat (4) exec_instr(2, 1'b0, 1'b0, 8'h00);
        checks++;
        if (ifc.pc !== 12'h400) begin
            errors++; $display("FAIL jms_target: got %h expected 400", ifc.pc);
        end
        for (int i = 0; i < 4; i++) begin
            exec_instr(1, 1'b0, 1'b0, 8'h00);
            checks++;
            if (ifc.pc !== want[i]) begin
                errors++; $display("FAIL bbl_pop_%0d: got %h expected %h", i, ifc.pc, want[i]);
            end
        end
    endtask

    task automatic test_fin();
        rom[12'h000] = 8'h42; rom[12'h001] = 8'h05;
        rom[12'h205] = 8'h30; rom[12'h27C] = 8'hA5;
        do_reset();
        exec_instr(2, 1'b0, 1'b0, 8'h00);
        exec_instr(2, 1'b0, 1'b0, 8'h7C);
        checks++;
        if (obs_addr2 !== 12'h27C) begin
            errors++; $display("FIN addr"); $display("FAIL fin_addr: got %h expected 27c", obs_addr2);
        end
        checks++;
        if (ifc.finData !== 8'hA5) begin
            errors++; $display("FAIL fin_data: got %h expected a5", ifc.finData);
        end
        checks++;
        if (ifc.pc !== 12'h206) begin
            errors++; $display("FAIL fin_pc: got %h expected 206", ifc.pc);
        end
        checks++;
        if ({ifc.opr, ifc.opa} !== 8'h30) begin
            errors++; $display("FAIL fin_opr_hold: got %h expected 30", {ifc.opr, ifc.opa});
        end
    endtask

    task automatic test_jin();
        rom[12'h000] = 8'h43; rom[12'h001] = 8'hF0; rom[12'h3F0] = 8'h31;
        do_reset();
        exec_instr(2, 1'b0, 1'b0, 8'h00);
        exec_instr(1, 1'b0, 1'b0, 8'h44);
        checks++;
        if (ifc.pc !== 12'h344) begin
            errors++; $display("FAIL jin_pc: got %h expected 344", ifc.pc);
        end
        checks++;
        if (obs_sec !== 0) begin
            errors++; $display("FAIL jin_single_cycle: got %0d expected 0", obs_sec);
        end
    endtask

    task automatic test_reset_mid_second();
        rom[12'h000] = 8'h43; rom[12'h001] = 8'h21;
        do_reset();
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (ifc.secondCycle !== 1'b1) begin
            errors++; $display("FAIL mid_in_second: got %b expected 1", ifc.secondCycle);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++; $display("FAIL mid_reset_state: got %h expected %h", out_vec(), RESET_VEC);
        end
        @(negedge clk);
        rstN = 1'b1;
        exec_instr(2, 1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_addr1 !== 12'h000) begin
            errors++; $display("FAIL mid_restart_addr: got %h expected 000", obs_addr1);
        end
        checks++;
        if (ifc.pc !== 12'h321) begin
            errors++; $display("FAIL mid_restart_pc: got %h expected 321", ifc.pc);
        end
    endtask

    // ---------------- randomized program vs. instruction-level model ----------------
    logic [11:0] exp_q[$];

    task automatic test_random_program();
        logic [11:0] m_pc, pc1, pc2, nxt;
        logic [11:0] m_stk [3];
        int          m_sp;
        logic [7:0]  b1, b2, fin, pair;
        logic [3:0]  mo, ma;
        logic        two, cc, isz;
        for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom_range(0, 255));
        m_pc = 12'h000;
        m_sp = 0;
        for (int i = 0; i < 3; i++) m_stk[i] = 12'h000;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            b1   = rom[m_pc];
            mo   = b1[7:4];
            ma   = b1[3:0];
            cc   = 1'($urandom_range(0, 1));
            isz  = 1'($urandom_range(0, 1));
            pair = 8'($urandom_range(0, 255));
            pc1  = m_pc + 12'd1;
            two  = (mo == 4'd1) || (mo == 4'd4) || (mo == 4'd5) || (mo == 4'd7) ||
                   (((mo == 4'd2) || (mo == 4'd3)) && !ma[0]);
            b2   = 8'h00;
            fin  = 8'h00;
            nxt  = pc1;
            if (two && mo == 4'd3) begin
                fin = rom[{pc1[11:8], pair}];
            end else if (two) begin
                b2  = rom[pc1];
                pc2 = pc1 + 12'd1;
                nxt = pc2;
                if (mo == 4'd4) nxt = {ma, b2};
                if (mo == 4'd5) begin
                    m_stk[m_sp] = pc2;
                    m_sp = (m_sp + 1) % 3;
                    nxt = {ma, b2};
                end
                if (mo == 4'd1 && cc)   nxt = {pc2[11:8], b2};
                if (mo == 4'd7 && !isz) nxt = {pc2[11:8], b2};
            end else if (mo == 4'd3) begin
                nxt = {pc1[11:8], pair};
            end else if (mo == 4'hC) begin
                m_sp = (m_sp + 2) % 3;
                nxt = m_stk[m_sp];
            end
            exp_q.push_back(nxt);
            exec_instr(two ? 2 : 1, cc, isz, pair);
            checks++;
            if (obs_addr1 !== m_pc) begin
                errors++; $display("FAIL rnd_fetch_%0d: got %h expected %h", n, obs_addr1, m_pc);
            end
            checks++;
            if ({ifc.opr, ifc.opa} !== b1) begin
                errors++; $display("FAIL rnd_opcode_%0d: got %h expected %h", n, {ifc.opr, ifc.opa}, b1);
            end
            checks++;
            if (obs_sec !== (two ? 8 : 0)) begin
                errors++; $display("FAIL rnd_second_%0d: got %0d expected %0d", n, obs_sec, two ? 8 : 0);
            end
            if (two && mo == 4'd3) begin
                checks++;
                if (ifc.finData !== fin || obs_addr2 !== {pc1[11:8], pair}) begin
                    errors++;
                    $display("FAIL rnd_fin_%0d: got data %h addr %h expected data %h addr %h",
                             n, ifc.finData, obs_addr2, fin, {pc1[11:8], pair});
                end
            end else if (two) begin
                checks++;
                if (ifc.byte2 !== b2) begin
                    errors++; $display("FAIL rnd_byte2_%0d: got %h expected %h", n, ifc.byte2, b2);
                end
            end
            m_pc = exp_q.pop_front();
            checks++;
            if (ifc.pc !== m_pc) begin
                errors++; $display("FAIL rnd_pc_%0d: got %h expected %h", n, ifc.pc, m_pc);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstN         = 1'b0;
        ifc.ccIn     = 1'b0;
        ifc.iszZero  = 1'b0;
        ifc.pairData = 8'h00;
        for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
        test_reset();
        test_jun();
        test_jcn();
        test_jms_bbl();
        test_fin();
        test_jin();
        test_reset_mid_second();
        test_random_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Produces the `opr`/`opa`/`cycle` stream consumed by the instruction decoder, acting as the fetch side of that interface.
- Owns the 8-phase machine cycle counter (A1..X3 = 0..7), the 12-bit program counter and the 3-level circular return stack.
- Drives ROM address nibbles on the multiplexed bus and captures instruction bytes from it.
- Handles two-cycle instructions and all PC redirection: JUN, JMS, JCN, ISZ, JIN, BBL and FIN indirect fetch.

Parameters:
- PC_W, 12, program counter width (fixed for 4004 compatibility; the three A-phase nibbles cover it).
- STACK_DEPTH, 3, return stack entries (circular).

Ports:
- clk  in  1  system clock, one phase per clock.
- rstN  in  1  asynchronous, active-low reset.
- romData  in  4  nibble from ROM bus, sampled at M1/M2.
- ccIn  in  1  condition result (CCout) from decoder, sampled at X3.
- iszZero  in  1  high when the ISZ increment result is 0, sampled at X3.
- pairData  in  8  selected register pair value (JIN/FIN address).
- cycle  out  3  current phase 0..7.
- sync  out  1  high during X3 (cycle==7), marks next A1.
- busOut  out  4  address nibble during A1..A3.
- busOe  out  1  high during A1..A3 only.
- opr  out  4  first-byte upper nibble of current instruction.
- opa  out  4  first-byte lower nibble.
- byte2  out  8  second byte of a two-cycle instruction (FIM data / jump target).
- finData  out  8  byte fetched by FIN second cycle.
- secondCycle  out  1  high during the second machine cycle of a two-cycle instruction.
- pc  out  12  program counter.

Behaviour:
- Reset values: cycle=0, pc=0, opr=0, opa=0, byte2=0, finData=0, secondCycle=0, stack entries=0, stack pointer=0.
  - Outputs derived from these: sync=0, busOe=1, busOut=0.
  - The first A1 after reset release presents address 0.
  - Reset mid-cycle aborts the instruction; no partial PC/stack update survives.
- Cycle counter: increments every clk, wraps 7->0. Free-running, no stall.
- Fetch address:
  - Normal: A1/A2/A3 drive pc[3:0], pc[7:4], pc[11:8].
  - FIN second cycle: address is {pc[11:8], pairData} and pc is not incremented.
- Capture:
  - First cycle: romData at cycle 3 -> opr, at cycle 4 -> opa.
  - Second cycle: romData at cycle 3 -> byte2[7:4], at cycle 4 -> byte2[3:0], or finData[7:4]/finData[3:0] for FIN.
  - opr/opa hold unchanged throughout the second cycle.
- PC increment: pc <= pc+1 (mod 4096) at end of cycle 4 of every machine cycle, except the FIN second cycle.
- Two-cycle classification is evaluated at end of cycle 4 of the first cycle, using the opr/opa just latched:
  - opr=1 (JCN), opr=2&opa[0]=0 (FIM), opr=3&opa[0]=0 (FIN), opr=4 (JUN), opr=5 (JMS), opr=7 (ISZ).
- State machine, two states:
  - FIRST -> SECOND at cycle 7 when the instruction is two-cycle.
  - SECOND -> FIRST always at cycle 7.
  - secondCycle = (state==SECOND).
- PC redirection at cycle 7 of the instruction's last machine cycle; these updates override the increment:
  - JUN: pc <= {opa, byte2}.
  - JMS: push incremented pc, then pc <= {opa, byte2}.
  - JCN: if ccIn, pc <= {pc[11:8], byte2}. The page is that of the already-incremented pc, so a jump lands in the next page when the second byte sits at xFF.
  - ISZ: if !iszZero, pc <= {pc[11:8], byte2}.
  - JIN (opr=3, opa[0]=1, single cycle): pc <= {pc[11:8], pairData}.
  - BBL (opr=C): pc <= pop.
- Stack:
  - Circular, 3 entries, pointer mod 3.
  - Push writes at the pointer, then advances it.
  - Pop retreats the pointer, then reads.
  - A 4th push silently overwrites the oldest entry.
  - Popping an empty stack returns whatever entry the wrapped pointer addresses. No error flag.
- No other opcode affects pc beyond the increment.

Decomposition:
- Shared package holds:
  - Phase constants A1..X3 = 0..7.
  - Opcode constants (JCN, FIM/SRC, FIN/JIN, JUN, JMS, ISZ, BBL), shared with the decoder.
  - The fetch state enum FIRST/SECOND.
- One natural sub-module: `return_stack3` (push/pop, 12-bit, circular pointer).

Test Plan:
- Reset release with ROM image NOP,NOP -> busOut sequence 0,0,0 then 1,0,0.
  - sync pulses every 8 clk.
  - opr=0 captured at cycle 3.
  - pc=1 after the first cycle 4.
- JUN at 0x000 with bytes 0x43,0x21 -> secondCycle high for one machine cycle, byte2=0x21, pc=0x321 after X3, next fetch address 0x321.
- JCN at 0x010 with bytes 0x1?,0x80:
  - ccIn=1 -> pc=0x080.
  - ccIn=0 -> pc=0x012.
  - Also place JCN at 0x0FE (byte2 at 0x0FF) with ccIn=1 -> pc=0x180 (page quirk).
- JMS x4 then BBL x4:
  - After 4 pushes the oldest return address is lost.
  - The pops return the 3 most recent addresses in LIFO order.
  - The 4th pop returns the wrapped entry.
- FIN at 0x205 with pairData=0x7C -> second-cycle bus address nibbles C,7,2, finData=ROM[0x27C], pc=0x206 after the instruction.
- JIN at 0x3F0 with pairData=0x44 -> pc=0x344 in one machine cycle.
- Assert rstN mid-SECOND cycle -> all outputs return to reset values immediately, and the fetch restarts at address 0.
